// File: rtl/tmds_encoder_pipe.sv
// rtl/tmds_encoder_pipe.sv - two-stage pipelined multi-lane TMDS encoder
// Define TMDS_TERC4_EN to build HDMI guard-band and TERC4 data-island symbols.
module tmds_encoder_pipe #(
  parameter int CHANNELS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             mode,
  input  logic [8*CHANNELS-1:0]  vd,
  input  logic [2*CHANNELS-1:0]  cd,
  input  logic [4*CHANNELS-1:0]  aux,
  output logic [10*CHANNELS-1:0] tmds
);
  localparam logic [2:0] MODE_VIDEO  = 3'd1;
`ifdef TMDS_TERC4_EN
  localparam logic [2:0] MODE_VGUARD = 3'd2;
  localparam logic [2:0] MODE_TERC4  = 3'd3;
  localparam logic [2:0] MODE_DGUARD = 3'd4;
`endif

  function automatic logic [3:0] f_pop8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int k = 0; k < 8; k++) n = n + {3'b000, v[k]};
    return n;
  endfunction

  function automatic logic [8:0] f_qm(input logic [7:0] v);
    logic [3:0] pop;
    logic       x;
    logic [8:0] q;
    pop  = f_pop8(v);
    x    = (pop > 4'd4) || (pop == 4'd4 && !v[0]);
    q[0] = v[0];
    for (int k = 1; k < 8; k++) q[k] = q[k-1] ^ v[k] ^ x;
    q[8] = ~x;
    return q;
  endfunction

  function automatic logic [9:0] f_ctrl(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

`ifdef TMDS_TERC4_EN
  function automatic logic [9:0] f_terc4(input logic [3:0] n);
    case (n)
      4'h0:    return 10'b1010011100;
      4'h1:    return 10'b1001100011;
      4'h2:    return 10'b1011100100;
      4'h3:    return 10'b1011100010;
      4'h4:    return 10'b0101110001;
      4'h5:    return 10'b0100011110;
      4'h6:    return 10'b0110001110;
      4'h7:    return 10'b0100111100;
      4'h8:    return 10'b1011001100;
      4'h9:    return 10'b0100111001;
      4'hA:    return 10'b0110011100;
      4'hB:    return 10'b1011000110;
      4'hC:    return 10'b1010001110;
      4'hD:    return 10'b1001110001;
      4'hE:    return 10'b0101100011;
      default: return 10'b1011000011;
    endcase
  endfunction
`else
  logic w_aux_unused;
  assign w_aux_unused = ^aux;
`endif

  logic [2:0] r_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mode <= '0;
    else        r_mode <= mode;
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
    logic [1:0]        r_cd;
    logic [8:0]        r_qm;
    logic [3:0]        r_n1;
    logic signed [4:0] r_cnt;
    logic [9:0]        r_tmds;
    logic [8:0]        w_qm;
    logic [9:0]        w_sym;
    logic signed [4:0] w_d;
    logic signed [4:0] w_cnt_nxt;
`ifdef TMDS_TERC4_EN
    localparam int ROLE = gi % 3;
    logic [3:0] r_aux;
`endif

    assign w_qm = f_qm(vd[8*gi +: 8]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cd <= '0;
        r_qm <= '0;
        r_n1 <= '0;
`ifdef TMDS_TERC4_EN
        r_aux <= '0;
`endif
      end else begin
        r_cd <= cd[2*gi +: 2];
        r_qm <= w_qm;
        r_n1 <= f_pop8(w_qm[7:0]);
`ifdef TMDS_TERC4_EN
        r_aux <= aux[4*gi +: 4];
`endif
      end
    end

    // Disparity fits in 5 signed bits, so all arithmetic is done modulo 32.
    always_comb begin
      w_d       = {r_n1, 1'b0} - 5'd8;
      w_sym     = f_ctrl(r_cd);
      w_cnt_nxt = '0;
      case (r_mode)
        MODE_VIDEO: begin
          if (r_cnt == 5'sd0 || w_d == 5'sd0) begin
            w_sym     = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
            w_cnt_nxt = r_qm[8] ? r_cnt + w_d : r_cnt - w_d;
          end else if ((r_cnt > 5'sd0 && w_d > 5'sd0) || (r_cnt < 5'sd0 && w_d < 5'sd0)) begin
            w_sym     = {1'b1, r_qm[8], ~r_qm[7:0]};
            w_cnt_nxt = r_cnt + (r_qm[8] ? 5'sd2 : 5'sd0) - w_d;
          end else begin
            w_sym     = {1'b0, r_qm[8], r_qm[7:0]};
            w_cnt_nxt = r_cnt - (r_qm[8] ? 5'sd0 : 5'sd2) + w_d;
          end
        end
`ifdef TMDS_TERC4_EN
        MODE_VGUARD: w_sym = (ROLE == 1) ? 10'b0100110011 : 10'b1011001100;
        MODE_TERC4:  w_sym = f_terc4(r_aux);
        MODE_DGUARD: w_sym = (ROLE == 0) ? f_terc4({2'b11, r_cd}) : 10'b0100110011;
`endif
        default: ;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt  <= '0;
        r_tmds <= '0;
      end else begin
        r_cnt  <= w_cnt_nxt;
        r_tmds <= w_sym;
      end
    end

    assign tmds[10*gi +: 10] = r_tmds;
  end

endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// tb/tb_tmds_encoder_pipe.sv - directed self-checking bench for tmds_encoder_pipe
module tb_tmds_encoder_pipe;
  localparam int CH = 4;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      mode;
  logic [8*CH-1:0] vd;
  logic [2*CH-1:0] cd;
  logic [4*CH-1:0] aux;
  logic [10*CH-1:0] tmds;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tmds_encoder_pipe #(.CHANNELS(CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .vd    (vd),
    .cd    (cd),
    .aux   (aux),
    .tmds  (tmds)
  );

  function automatic logic [9:0] lane(input int i);
    return tmds[10*i +: 10];
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    tick;
    tick;
  endtask

  task automatic video(input logic [7:0] b);
    mode = 3'd1;
    vd   = {CH{b}};
  endtask

  initial begin
    rst_n = 1'b0;
    mode  = 3'd0;
    vd    = '0;
    cd    = '0;
    aux   = '0;

    #12;
    for (int i = 0; i < CH; i++) chk($sformatf("reset_lane%0d", i), lane(i), 10'd0);

    @(negedge clk);
    rst_n = 1'b1;
    tick;
    for (int i = 0; i < CH; i++) chk($sformatf("release_lane%0d", i), lane(i), C00);

    cd = 8'b00_00_00_11;
    tick;
    chk("ctl_latency", lane(0), C00);
    tick;
    chk("ctl11_lane0", lane(0), C11);
    chk("ctl00_lane1", lane(1), C00);

    cd = '0;
    video(8'h00);
    tick;
    tick;
    chk("bal0_lane0", lane(0), 10'h100);
    chk("bal0_lane3", lane(3), 10'h100);
    tick;
    chk("bal1_lane0", lane(0), 10'h3FF);
    chk("bal1_lane3", lane(3), 10'h3FF);
    mode = 3'd0;
    tick;
    chk("bal2_lane0", lane(0), 10'h100);
    chk("bal2_lane3", lane(3), 10'h100);
    video(8'h00);
    tick;
    chk("gap_ctl", lane(0), C00);
    mode = 3'd0;
    tick;
    chk("clear_lane0", lane(0), 10'h100);
    chk("clear_lane3", lane(3), 10'h100);

    video(8'h0F);
    tick;
    video(8'h1E);
    tick;
    chk("vid0F", lane(0), 10'h105);
    video(8'hFF);
    tick;
    chk("vid1E", lane(0), 10'h25F);
    tick;
    chk("vidFF_a", lane(0), 10'h200);
    tick;
    chk("vidFF_b", lane(0), 10'h0FF);
    tick;
    chk("vidFF_c", lane(0), 10'h0FF);
    tick;
    chk("vidFF_d", lane(0), 10'h200);
    chk("vidFF_d_lane3", lane(3), 10'h200);

    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_lane0", lane(0), 10'd0);
    chk("async_rst_lane3", lane(3), 10'd0);
    @(negedge clk);
    rst_n = 1'b1;
    video(8'h00);
    tick;
    chk("rst_restart_ctl", lane(0), C00);
    tick;
    chk("rst_restart_vid", lane(0), 10'h100);

`ifdef TMDS_TERC4_EN
    mode = 3'd3;
    aux  = 16'h000A;
    cd   = '0;
    settle;
    chk("terc4_A_lane0", lane(0), 10'b0110011100);
    chk("terc4_0_lane1", lane(1), 10'b1010011100);

    mode = 3'd4;
    cd   = 8'b00_00_00_10;
    settle;
    chk("dguard_lane0", lane(0), 10'b0101100011);
    chk("dguard_lane1", lane(1), 10'b0100110011);
    chk("dguard_lane2", lane(2), 10'b0100110011);
    chk("dguard_lane3", lane(3), 10'b1010001110);

    mode = 3'd2;
    settle;
    chk("vguard_lane0", lane(0), 10'b1011001100);
    chk("vguard_lane1", lane(1), 10'b0100110011);
    chk("vguard_lane2", lane(2), 10'b1011001100);
`else
    mode = 3'd3;
    cd   = 8'b01_01_01_01;
    aux  = 16'hFFFF;
    settle;
    for (int i = 0; i < CH; i++) chk($sformatf("dvi_m3_lane%0d", i), lane(i), C01);

    mode = 3'd2;
    cd   = 8'b10_10_10_10;
    settle;
    chk("dvi_m2_lane0", lane(0), C10);
    chk("dvi_m2_lane3", lane(3), C10);

    mode = 3'd7;
    cd   = 8'b11_11_11_11;
    settle;
    chk("dvi_m7_lane1", lane(1), C11);
`endif

    cd = '0;
    video(8'h00);
    settle;
    chk("post_mode_vid", lane(0), 10'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
